// File: rtl/liang_pkg.sv
// Shared core definitions: bus widths and the load/store unit request and
// response types exchanged between the execute stage and pipe_lsu.
package liang_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int XLEN       = DATA_WIDTH;

    // Access size encoding carried in the request
    typedef enum logic [1:0] {
        LSU_B = 2'd0,
        LSU_H = 2'd1,
        LSU_W = 2'd2
    } lsu_size_e;

    typedef struct packed {
        logic                  is_store;
        lsu_size_e             size;
        logic                  is_unsigned;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } lsu_req_t;

    typedef struct packed {
        logic [XLEN-1:0] rdata;
        logic            err;
    } lsu_resp_t;

    // True when the access cannot be served by a single aligned bus word.
    // Any size other than B/H is treated as a word access.
    function automatic logic lsu_misaligned(input lsu_size_e size,
                                            input logic [1:0] addr_lo);
        logic mis;
        case (size)
            LSU_B:   mis = 1'b0;
            LSU_H:   mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: places store data and
// strobes on the bus lanes, and extracts/extends load data from a bus word.
module lsu_align
    import liang_pkg::*;
(
    // store path
    input  logic [1:0]            st_addr_lo,
    input  lsu_size_e             st_size,
    input  logic [DATA_WIDTH-1:0] st_wdata,
    output logic [DATA_WIDTH-1:0] st_bus_wdata,
    output logic [STRB_WIDTH-1:0] st_bus_wstrb,
    // load path
    input  logic [1:0]            ld_addr_lo,
    input  lsu_size_e             ld_size,
    input  logic                  ld_unsigned,
    input  logic [DATA_WIDTH-1:0] ld_bus_rdata,
    output logic [XLEN-1:0]       ld_data
);

    logic [STRB_WIDTH-1:0] base_strb;
    logic [DATA_WIDTH-1:0] ld_shifted;

    // Store lane placement: shift data and size mask up to the addressed byte
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        base_strb = 4'b1111;
        case (st_size)
            LSU_B:   base_strb = 4'b0001;
            LSU_H:   base_strb = 4'b0011;
            default: base_strb = 4'b1111;
        endcase
        st_bus_wdata = st_wdata << {st_addr_lo, 3'b000};
        st_bus_wstrb = base_strb << st_addr_lo;
    end

    // Load extraction: bring the addressed byte to lane 0, truncate, extend
    always_comb begin
        ld_shifted = ld_bus_rdata >> {ld_addr_lo, 3'b000};
        ld_data    = ld_shifted;
        case (ld_size)
            LSU_B:   ld_data = ld_unsigned ? {{(XLEN-8){1'b0}}, ld_shifted[7:0]}
                                           : {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
            LSU_H:   ld_data = ld_unsigned ? {{(XLEN-16){1'b0}}, ld_shifted[15:0]}
                                           : {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
            default: ld_data = ld_shifted;
        endcase
    end

endmodule

// File: rtl/pipe_lsu.sv
// Load/store unit: accepts one request at a time from execute, runs a single
// AXI-lite read or write, and returns aligned load data or a store completion.
module pipe_lsu
    import liang_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // request from execute
    input  logic                  lsu_req_valid_i,
    output logic                  lsu_req_ready_o,
    input  lsu_req_t              lsu_req_i,
    // response to execute
    output logic                  lsu_resp_valid_o,
    input  logic                  lsu_resp_ready_i,
    output lsu_resp_t             lsu_resp_o,
    // AXI-lite read address
    output logic [ADDR_WIDTH-1:0] lsu_araddr_o,
    output logic                  lsu_arvalid_o,
    input  logic                  lsu_arready_i,
    // AXI-lite read data
    input  logic [DATA_WIDTH-1:0] lsu_rdata_i,
    input  logic                  lsu_rvalid_i,
    output logic                  lsu_rready_o,
    // AXI-lite write address
    output logic [ADDR_WIDTH-1:0] lsu_awaddr_o,
    output logic                  lsu_awvalid_o,
    input  logic                  lsu_awready_i,
    // AXI-lite write data
    output logic [DATA_WIDTH-1:0] lsu_wdata_o,
    output logic [STRB_WIDTH-1:0] lsu_wstrb_o,
    output logic                  lsu_wvalid_o,
    input  logic                  lsu_wready_i,
    // AXI-lite write response
    input  logic [1:0]            lsu_bresp_i,
    input  logic                  lsu_bvalid_i,
    output logic                  lsu_bready_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR,
        ST_WR_RESP,
        ST_RESP
    } state_e;

    state_e                state;
    logic [1:0]            ld_addr_lo;
    lsu_size_e             ld_size;
    logic                  ld_unsigned;
    logic [DATA_WIDTH-1:0] st_bus_wdata;
    logic [STRB_WIDTH-1:0] st_bus_wstrb;
    logic [XLEN-1:0]       ld_data;
    logic                  req_fire;
    logic                  aw_done;
    logic                  w_done;

    // Handshake and write-channel completion terms used by the FSM
    always_comb begin
        req_fire = lsu_req_ready_o && lsu_req_valid_i;
        aw_done  = !lsu_awvalid_o || lsu_awready_i;
        w_done   = !lsu_wvalid_o  || lsu_wready_i;
    end

    // Store lanes come straight from the incoming request; load extraction
    // uses the fields latched at acceptance.
    lsu_align u_align (
        .st_addr_lo   (lsu_req_i.addr[1:0]),
        .st_size      (lsu_req_i.size),
        .st_wdata     (lsu_req_i.wdata),
        .st_bus_wdata (st_bus_wdata),
        .st_bus_wstrb (st_bus_wstrb),
        .ld_addr_lo   (ld_addr_lo),
        .ld_size      (ld_size),
        .ld_unsigned  (ld_unsigned),
        .ld_bus_rdata (lsu_rdata_i),
        .ld_data      (ld_data)
    );

    // Transaction FSM with all bus and response outputs registered
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state            <= ST_IDLE;
            ld_addr_lo       <= 2'b00;
            ld_size          <= LSU_B;
            ld_unsigned      <= 1'b0;
            lsu_req_ready_o  <= 1'b0;
            lsu_resp_valid_o <= 1'b0;
            lsu_resp_o       <= '0;
            lsu_araddr_o     <= '0;
            lsu_arvalid_o    <= 1'b0;
            lsu_rready_o     <= 1'b0;
            lsu_awaddr_o     <= '0;
            lsu_awvalid_o    <= 1'b0;
            lsu_wdata_o      <= '0;
            lsu_wstrb_o      <= '0;
            lsu_wvalid_o     <= 1'b0;
            lsu_bready_o     <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            case (state)
                ST_IDLE: begin
                    lsu_req_ready_o <= 1'b1;
                    if (req_fire) begin
                        lsu_req_ready_o <= 1'b0;
                        ld_addr_lo      <= lsu_req_i.addr[1:0];
                        ld_size         <= lsu_req_i.size;
                        ld_unsigned     <= lsu_req_i.is_unsigned;
                        if (lsu_misaligned(lsu_req_i.size, lsu_req_i.addr[1:0])) begin
                            lsu_resp_o       <= '{rdata: '0, err: 1'b1};
                            lsu_resp_valid_o <= 1'b1;
                            state            <= ST_RESP;
                        end else if (lsu_req_i.is_store) begin
                            lsu_awaddr_o  <= {lsu_req_i.addr[ADDR_WIDTH-1:2], 2'b00};
                            lsu_wdata_o   <= st_bus_wdata;
                            lsu_wstrb_o   <= st_bus_wstrb;
                            lsu_awvalid_o <= 1'b1;
                            lsu_wvalid_o  <= 1'b1;
                            state         <= ST_WR;
                        end else begin
                            lsu_araddr_o  <= {lsu_req_i.addr[ADDR_WIDTH-1:2], 2'b00};
                            lsu_arvalid_o <= 1'b1;
                            state         <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (lsu_arready_i) begin
                        lsu_arvalid_o <= 1'b0;
                        lsu_rready_o  <= 1'b1;
                        state         <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (lsu_rvalid_i) begin
                        lsu_rready_o     <= 1'b0;
                        lsu_resp_o       <= '{rdata: ld_data, err: 1'b0};
                        lsu_resp_valid_o <= 1'b1;
                        state            <= ST_RESP;
                    end
                end
                ST_WR: begin
                    // AW and W retire independently; move on once both are done
                    if (lsu_awvalid_o && lsu_awready_i) lsu_awvalid_o <= 1'b0;
                    if (lsu_wvalid_o && lsu_wready_i)   lsu_wvalid_o  <= 1'b0;
                    if (aw_done && w_done) begin
                        lsu_bready_o <= 1'b1;
                        state        <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (lsu_bvalid_i) begin
                        lsu_bready_o     <= 1'b0;
                        lsu_resp_o       <= '{rdata: '0, err: (lsu_bresp_i != 2'b00)};
                        lsu_resp_valid_o <= 1'b1;
                        state            <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (lsu_resp_ready_i) begin
                        lsu_resp_valid_o <= 1'b0;
                        lsu_req_ready_o  <= 1'b1;
                        state            <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_lsu.sv
// Directed bench for pipe_lsu: the bench plays both execute stage and
// AXI-lite slave, stepping cycle by cycle with hand-computed expectations.
module tb_pipe_lsu;
    import liang_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b1;
    logic                  lsu_req_valid_i = 1'b0;
    logic                  lsu_req_ready_o;
    lsu_req_t              lsu_req_i = '0;
    logic                  lsu_resp_valid_o;
    logic                  lsu_resp_ready_i = 1'b0;
    lsu_resp_t             lsu_resp_o;
    logic [ADDR_WIDTH-1:0] lsu_araddr_o;
    logic                  lsu_arvalid_o;
    logic                  lsu_arready_i = 1'b0;
    logic [DATA_WIDTH-1:0] lsu_rdata_i = '0;
    logic                  lsu_rvalid_i = 1'b0;
    logic                  lsu_rready_o;
    logic [ADDR_WIDTH-1:0] lsu_awaddr_o;
    logic                  lsu_awvalid_o;
    logic                  lsu_awready_i = 1'b0;
    logic [DATA_WIDTH-1:0] lsu_wdata_o;
    logic [STRB_WIDTH-1:0] lsu_wstrb_o;
    logic                  lsu_wvalid_o;
    logic                  lsu_wready_i = 1'b0;
    logic [1:0]            lsu_bresp_i = 2'b00;
    logic                  lsu_bvalid_i = 1'b0;
    logic                  lsu_bready_o;

    int checks = 0;
    int errors = 0;

    pipe_lsu dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .lsu_req_valid_i  (lsu_req_valid_i),
        .lsu_req_ready_o  (lsu_req_ready_o),
        .lsu_req_i        (lsu_req_i),
        .lsu_resp_valid_o (lsu_resp_valid_o),
        .lsu_resp_ready_i (lsu_resp_ready_i),
        .lsu_resp_o       (lsu_resp_o),
        .lsu_araddr_o     (lsu_araddr_o),
        .lsu_arvalid_o    (lsu_arvalid_o),
        .lsu_arready_i    (lsu_arready_i),
        .lsu_rdata_i      (lsu_rdata_i),
        .lsu_rvalid_i     (lsu_rvalid_i),
        .lsu_rready_o     (lsu_rready_o),
        .lsu_awaddr_o     (lsu_awaddr_o),
        .lsu_awvalid_o    (lsu_awvalid_o),
        .lsu_awready_i    (lsu_awready_i),
        .lsu_wdata_o      (lsu_wdata_o),
        .lsu_wstrb_o      (lsu_wstrb_o),
        .lsu_wvalid_o     (lsu_wvalid_o),
        .lsu_wready_i     (lsu_wready_i),
        .lsu_bresp_i      (lsu_bresp_i),
        .lsu_bvalid_i     (lsu_bvalid_i),
        .lsu_bready_o     (lsu_bready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one clock and settle past the edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // present a request for one accept edge; leaves the bench in cycle 1
    task automatic send(input logic st, input lsu_size_e sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d);
        lsu_req_i       = '{is_store: st, size: sz, is_unsigned: uns, addr: a, wdata: d};
        lsu_req_valid_i = 1'b1;
        check("req_ready_at_accept", {31'b0, lsu_req_ready_o}, 32'd1);
        step();
        lsu_req_valid_i = 1'b0;
    endtask

    // zero-wait read slave from cycle 1 onward; ends with resp_valid sampled
    task automatic read_beat(input logic [31:0] exp_araddr, input logic [31:0] rd);
        check("arvalid_c1", {31'b0, lsu_arvalid_o}, 32'd1);
        check("araddr", lsu_araddr_o, exp_araddr);
        lsu_arready_i = 1'b1;
        step();
        lsu_arready_i = 1'b0;
        check("rready_c2", {31'b0, lsu_rready_o}, 32'd1);
        lsu_rvalid_i = 1'b1;
        lsu_rdata_i  = rd;
        step();
        lsu_rvalid_i = 1'b0;
        check("rready_dropped", {31'b0, lsu_rready_o}, 32'd0);
    endtask

    // consume the response and confirm return to idle
    task automatic take_resp();
        lsu_resp_ready_i = 1'b1;
        step();
        lsu_resp_ready_i = 1'b0;
        check("resp_valid_after_take", {31'b0, lsu_resp_valid_o}, 32'd0);
        check("req_ready_after_take", {31'b0, lsu_req_ready_o}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int resp_count;
        lsu_resp_t held;

        // ---- reset ----
        #2 rst_ni = 1'b0;
        #1;
        check("rst_req_ready", {31'b0, lsu_req_ready_o}, 32'd0);
        check("rst_resp_valid", {31'b0, lsu_resp_valid_o}, 32'd0);
        check("rst_arvalid", {31'b0, lsu_arvalid_o}, 32'd0);
        check("rst_awvalid", {31'b0, lsu_awvalid_o}, 32'd0);
        check("rst_resp", lsu_resp_o.rdata, 32'd0);
        check("rst_wstrb", {28'b0, lsu_wstrb_o}, 32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        check("req_ready_before_edge", {31'b0, lsu_req_ready_o}, 32'd0);
        step();
        check("req_ready_first_cycle", {31'b0, lsu_req_ready_o}, 32'd1);

        // ---- LB 0x8000_0003, rdata 0x80FF_1234 -> 0xFFFF_FF80 ----
        send(1'b0, LSU_B, 1'b0, 32'h8000_0003, 32'h0);
        check("lb_req_ready_busy", {31'b0, lsu_req_ready_o}, 32'd0);
        read_beat(32'h8000_0000, 32'h80FF_1234);
        check("lb_resp_valid_c3", {31'b0, lsu_resp_valid_o}, 32'd1);
        check("lb_rdata", lsu_resp_o.rdata, 32'hFFFF_FF80);
        check("lb_err", {31'b0, lsu_resp_o.err}, 32'd0);
        take_resp();

        // ---- LBU same address -> 0x0000_0080 ----
        send(1'b0, LSU_B, 1'b1, 32'h8000_0003, 32'h0);
        read_beat(32'h8000_0000, 32'h80FF_1234);
        check("lbu_rdata", lsu_resp_o.rdata, 32'h0000_0080);
        take_resp();

        // ---- SH 0x8000_0002, wdata 0xABCD ----
        send(1'b1, LSU_H, 1'b0, 32'h8000_0002, 32'h0000_ABCD);
        check("sh_awvalid", {31'b0, lsu_awvalid_o}, 32'd1);
        check("sh_wvalid", {31'b0, lsu_wvalid_o}, 32'd1);
        check("sh_awaddr", lsu_awaddr_o, 32'h8000_0000);
        check("sh_wdata", lsu_wdata_o, 32'hABCD_0000);
        check("sh_wstrb", {28'b0, lsu_wstrb_o}, 32'h0000_000C);
        check("sh_arvalid", {31'b0, lsu_arvalid_o}, 32'd0);
        lsu_awready_i = 1'b1;
        lsu_wready_i  = 1'b1;
        step();
        lsu_awready_i = 1'b0;
        lsu_wready_i  = 1'b0;
        check("sh_aw_dropped", {31'b0, lsu_awvalid_o}, 32'd0);
        check("sh_w_dropped", {31'b0, lsu_wvalid_o}, 32'd0);
        check("sh_bready", {31'b0, lsu_bready_o}, 32'd1);
        lsu_bvalid_i = 1'b1;
        lsu_bresp_i  = 2'b00;
        step();
        lsu_bvalid_i = 1'b0;
        check("sh_resp_valid_c3", {31'b0, lsu_resp_valid_o}, 32'd1);
        check("sh_err", {31'b0, lsu_resp_o.err}, 32'd0);
        check("sh_rdata", lsu_resp_o.rdata, 32'd0);
        check("sh_bready_dropped", {31'b0, lsu_bready_o}, 32'd0);
        take_resp();

        // ---- SW with awready three cycles after wready ----
        send(1'b1, LSU_W, 1'b0, 32'h8000_0010, 32'h1122_3344);
        check("sw_wdata", lsu_wdata_o, 32'h1122_3344);
        check("sw_wstrb", {28'b0, lsu_wstrb_o}, 32'h0000_000F);
        lsu_wready_i = 1'b1;
        step();
        lsu_wready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("sw_w_dropped", {31'b0, lsu_wvalid_o}, 32'd0);
            check("sw_aw_held", {31'b0, lsu_awvalid_o}, 32'd1);
            check("sw_awaddr_held", lsu_awaddr_o, 32'h8000_0010);
            check("sw_no_bready", {31'b0, lsu_bready_o}, 32'd0);
            if (i < 2) step();
        end
        lsu_awready_i = 1'b1;
        step();
        lsu_awready_i = 1'b0;
        check("sw_aw_dropped", {31'b0, lsu_awvalid_o}, 32'd0);
        check("sw_bready", {31'b0, lsu_bready_o}, 32'd1);
        lsu_bvalid_i = 1'b1;
        step();
        lsu_bvalid_i = 1'b0;
        resp_count = lsu_resp_valid_o ? 1 : 0;
        lsu_resp_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (lsu_resp_valid_o) resp_count++;
        end
        lsu_resp_ready_i = 1'b0;
        check("sw_one_response", resp_count, 32'd1);

        // ---- LW misaligned 0x8000_0002 ----
        send(1'b0, LSU_W, 1'b0, 32'h8000_0002, 32'h0);
        check("mis_resp_valid_c1", {31'b0, lsu_resp_valid_o}, 32'd1);
        check("mis_err", {31'b0, lsu_resp_o.err}, 32'd1);
        check("mis_rdata", lsu_resp_o.rdata, 32'd0);
        check("mis_arvalid", {31'b0, lsu_arvalid_o}, 32'd0);
        check("mis_awvalid", {31'b0, lsu_awvalid_o}, 32'd0);
        take_resp();
        check("mis_arvalid_after", {31'b0, lsu_arvalid_o}, 32'd0);

        // ---- SB 0x8000_0001 with bresp SLVERR ----
        send(1'b1, LSU_B, 1'b0, 32'h8000_0001, 32'h0000_005A);
        check("sb_wdata", lsu_wdata_o, 32'h0000_5A00);
        check("sb_wstrb", {28'b0, lsu_wstrb_o}, 32'h0000_0002);
        lsu_awready_i = 1'b1;
        lsu_wready_i  = 1'b1;
        step();
        lsu_awready_i = 1'b0;
        lsu_wready_i  = 1'b0;
        lsu_bvalid_i  = 1'b1;
        lsu_bresp_i   = 2'b10;
        step();
        lsu_bvalid_i = 1'b0;
        lsu_bresp_i  = 2'b00;
        check("sb_err", {31'b0, lsu_resp_o.err}, 32'd1);
        take_resp();

        // ---- LH 0x8000_0002 with response backpressure ----
        send(1'b0, LSU_H, 1'b0, 32'h8000_0002, 32'h0);
        read_beat(32'h8000_0000, 32'hBEEF_1234);
        check("lh_rdata", lsu_resp_o.rdata, 32'hFFFF_BEEF);
        held = lsu_resp_o;
        lsu_req_i       = '{is_store: 1'b0, size: LSU_W, is_unsigned: 1'b0,
                            addr: 32'h8000_0020, wdata: 32'h0};
        lsu_req_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_resp_valid", {31'b0, lsu_resp_valid_o}, 32'd1);
            check("bp_resp_stable", lsu_resp_o.rdata, held.rdata);
            check("bp_req_ready", {31'b0, lsu_req_ready_o}, 32'd0);
            check("bp_arvalid", {31'b0, lsu_arvalid_o}, 32'd0);
        end
        lsu_resp_ready_i = 1'b1;
        step();
        lsu_resp_ready_i = 1'b0;
        check("bp_idle_ready", {31'b0, lsu_req_ready_o}, 32'd1);
        check("bp_not_yet_issued", {31'b0, lsu_arvalid_o}, 32'd0);
        step();
        lsu_req_valid_i = 1'b0;
        read_beat(32'h8000_0020, 32'hCAFE_F00D);
        check("lw_rdata", lsu_resp_o.rdata, 32'hCAFE_F00D);
        take_resp();

        // ---- reset asserted during RD_DATA ----
        send(1'b0, LSU_B, 1'b1, 32'h8000_0000, 32'h0);
        lsu_arready_i = 1'b1;
        step();
        lsu_arready_i = 1'b0;
        check("rst_mid_rready_before", {31'b0, lsu_rready_o}, 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_mid_arvalid", {31'b0, lsu_arvalid_o}, 32'd0);
        check("rst_mid_rready", {31'b0, lsu_rready_o}, 32'd0);
        check("rst_mid_resp_valid", {31'b0, lsu_resp_valid_o}, 32'd0);
        check("rst_mid_req_ready", {31'b0, lsu_req_ready_o}, 32'd0);
        #1 rst_ni = 1'b1;
        step();
        check("rst_mid_req_ready_after", {31'b0, lsu_req_ready_o}, 32'd1);
        check("rst_mid_rready_after", {31'b0, lsu_rready_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_lsu.md
# pipe_lsu

Load/store unit for the pipelined core. It is the AXI-lite initiator on the arbiter's `lsu_*` port pair. It accepts one memory request at a time from the execute stage and performs one AXI-lite read or write. It then returns a single response carrying load data, aligned and sign- or zero-extended, or a store completion, plus an error flag.

## Interface
Parameters (from `liang_pkg`):
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: bus data width; equals `XLEN`.
- `STRB_WIDTH`, 4: `DATA_WIDTH/8`.

Ports:
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset; one clock, asynchronous, active-low.
- `lsu_req_valid_i` input 1: request valid.
- `lsu_req_ready_o` output 1: request accepted when high with valid.
- `lsu_req_i` input `lsu_req_t`: `{is_store, size[1:0] (0=B, 1=H, 2=W), is_unsigned, addr, wdata}`.
- `lsu_resp_valid_o` output 1: response valid.
- `lsu_resp_ready_i` input 1: response consumed.
- `lsu_resp_o` output `lsu_resp_t`: `{rdata[XLEN], err}`.
- `lsu_araddr_o`, `lsu_arvalid_o`, `lsu_arready_i`: AXI-lite read address channel.
- `lsu_rdata_i`, `lsu_rvalid_i`, `lsu_rready_o`: AXI-lite read data channel. There is no rresp.
- `lsu_awaddr_o` (`ADDR_WIDTH`), `lsu_awvalid_o`, `lsu_awready_i`: AXI-lite write address channel.
- `lsu_wdata_o`, `lsu_wstrb_o`, `lsu_wvalid_o`, `lsu_wready_i`: AXI-lite write data channel.
- `lsu_bresp_i` [1:0], `lsu_bvalid_i`, `lsu_bready_o`: AXI-lite write response channel.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR (AW+W), WR_RESP, RESP.
- IDLE:
  - `lsu_req_ready_o`=1.
  - On handshake, latch the request and check alignment. H is misaligned when addr[0]=1. W is misaligned when addr[1:0]≠0.
  - Misaligned → RESP with err=1, rdata=0, no bus traffic.
  - Aligned load → RD_ADDR. Aligned store → WR.
- RD_ADDR:
  - `arvalid`=1, `araddr`=addr & ~3.
  - On arready → RD_DATA.
- RD_DATA:
  - `rready`=1.
  - On rvalid: shift `rdata` right by 8·addr[1:0], truncate to size, then sign-extend or zero-extend according to `is_unsigned`. W ignores `is_unsigned`. Latch the result, err=0, → RESP.
- WR:
  - On entry, both `awvalid` and `wvalid` go high. `awaddr`=addr & ~3.
  - `wdata`=wdata << 8·addr[1:0].
  - `wstrb` is 4'b0001, 4'b0011 or 4'b1111 for B/H/W, shifted left by addr[1:0].
  - Each valid drops independently after its own handshake. Both may complete in the same cycle, in either order.
  - When both are done → WR_RESP.
- WR_RESP:
  - `bready`=1.
  - On bvalid, err = (bresp≠2'b00), rdata=0, → RESP.
- RESP:
  - `lsu_resp_valid_o`=1; `lsu_resp_o` is held stable.
  - On `lsu_resp_ready_i` → IDLE.
- Only one outstanding transaction exists. No new request is accepted until the response handshake completes.
- Address and data outputs hold their values while the corresponding valid is high.

## Timing
- Reset values: all valid and ready outputs are 0; `lsu_resp_o`=0; address, data and strobe outputs are 0; state is IDLE. `lsu_req_ready_o` rises in the first cycle after deassertion.
- Reset asserted mid-transaction aborts to IDLE immediately. All valids drop asynchronously. Any in-flight bus beat is abandoned; the arbiter is reset in the same domain.
- Load, zero-wait slave: request accepted cycle 0, arvalid cycle 1, arready cycle 1, rvalid cycle 2, `resp_valid` cycle 3. Minimum latency is 3 cycles.
- Store, zero-wait slave: aw/w handshake cycle 1, bvalid cycle 2, `resp_valid` cycle 3.
- Misaligned request: `resp_valid` in cycle 1.
- Response backpressure holds RESP indefinitely with the output stable.
- The unit never asserts `rready` or `bready` outside RD_DATA or WR_RESP.

## Structure
- Add `lsu_req_t`, `lsu_resp_t` and the size encoding (`LSU_B`, `LSU_H`, `LSU_W`) to `liang_pkg`, next to `ADDR_WIDTH`, `DATA_WIDTH` and `STRB_WIDTH`.
- One sub-module, `lsu_align`, is combinational:
  - Store path: wdata/wstrb lane placement.
  - Load path: lane extraction and sign/zero extension.
- In `top`, connect the `lsu_*` ports to `axi_lite_arbiter`. Widen the `lsu_awaddr` net to `ADDR_WIDTH`.

## Test plan
- LB, addr 0x8000_0003, slave rdata 0x80FF_1234 → rdata 0xFFFF_FF80, err=0. Same request as LBU → 0x0000_0080. Check `araddr`=0x8000_0000.
- SH, addr 0x8000_0002, wdata 0x0000_ABCD → `awaddr` 0x8000_0000, `wdata` 0xABCD_0000, `wstrb` 4'b1100. After bvalid with bresp 0 → `resp_valid` with err=0.
- SW where awready arrives 3 cycles after wready:
  - `wvalid` drops after its handshake while `awvalid` stays high.
  - `bready` is asserted only after both handshakes.
  - Exactly one response is produced.
- LW at 0x8000_0002 → err=1, rdata=0 at cycle 1, with no `arvalid` or `awvalid` ever asserted.
- SB with bresp 2'b10 → err=1.
- Load with `resp_ready` held low for 5 cycles: the response stays stable, `req_ready` stays 0, and a new request is accepted only after the response handshake.
- Assert `rst_ni` low during RD_DATA: `arvalid`, `rready` and `resp_valid` drop immediately, and `req_ready` returns to 1 the cycle after release.
